// File: rtl/timer_pkg.sv
// Timer shared definitions: register offsets, tap-select mapping, FSM state encoding.
package timer_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TAP_W = 4;
  localparam int unsigned OFF_W = 2;

  // Register offsets relative to BASE
  localparam logic [OFF_W-1:0] OFF_DIV  = 2'd0;
  localparam logic [OFF_W-1:0] OFF_TIMA = 2'd1;
  localparam logic [OFF_W-1:0] OFF_TMA  = 2'd2;
  localparam logic [OFF_W-1:0] OFF_TAC  = 2'd3;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_OVF = 1'b1
  } state_e;

  // TAC[1:0] -> prescaler counter bit watched for falling edges
  function automatic logic [TAP_W-1:0] tac_tap(input logic [1:0] sel);
    logic [TAP_W-1:0] tap;
    tap = 4'd9;
    case (sel)
      2'b00:   tap = 4'd9;
      2'b01:   tap = 4'd3;
      2'b10:   tap = 4'd5;
      default: tap = 4'd7;
    endcase
    return tap;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Timer prescaler: 16-bit free-running counter, tap mux and falling-edge tick detector.
// Macro TIMER_DIV_GLITCH_EN lets DIV/TAC writes that drop the tapped signal produce a tick.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       div_wr_i,
  input  logic       tac_wr_i,
  input  logic [2:0] tac_next_i,
  output logic [7:0] div_o,
  output logic       tick_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hist_q;
  logic             sig_next;

  // Next counter value, tapped signal after this edge, and its falling edge
  always_comb begin
    cnt_d    = div_wr_i ? '0 : cnt_q + CNT_W'(1);
    sig_next = tac_next_i[2] & cnt_d[tac_tap(tac_next_i[1:0])];
`ifdef TIMER_DIV_GLITCH_EN
    tick_c_o = hist_q & ~sig_next;
`else
    // History is simply re-sampled across DIV/TAC writes, so they never tick
    tick_c_o = hist_q & ~sig_next & ~(div_wr_i | tac_wr_i);
`endif
  end

`ifdef TIMER_DIV_GLITCH_EN
  logic tac_wr_unused;
  assign tac_wr_unused = tac_wr_i;
`endif

  // Counter and edge-history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      hist_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hist_q <= sig_next;
    end
  end

  assign div_o = cnt_q[CNT_W-1:CNT_W-8];

endmodule

// File: rtl/timer.sv
// Timer top: bus decode, TIMA/TMA/TAC registers and overflow-reload FSM.
// Macro TIMER_DIV_GLITCH_EN (see timer_prescaler) enables write-induced ticks.
module timer
  import timer_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'hFF04,
  parameter int unsigned OVF_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_w,
  input  logic        cpu_do_write,
  output logic [7:0]  data_r,
  output logic        data_active,
  output logic        irq
);

  localparam int unsigned DW      = 8;
  localparam int unsigned OC_W    = (OVF_DELAY > 1) ? $clog2(OVF_DELAY) : 1;
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(OVF_DELAY - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   tima_q, tima_d;
  logic [DW-1:0]   tma_q, tma_d;
  logic [2:0]      tac_q, tac_d;
  logic [OC_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic            irq_q, irq_d;

  logic [15:0]     off_c;
  logic            wr_div, wr_tima, wr_tma, wr_tac;
  logic [DW-1:0]   div_val;
  logic            tick_c;

  timer_prescaler u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .div_wr_i   (wr_div),
    .tac_wr_i   (wr_tac),
    .tac_next_i (tac_d),
    .div_o      (div_val),
    .tick_c_o   (tick_c)
  );

  // Address decode and write strobes
  always_comb begin
    off_c       = cpu_addr - BASE;
    data_active = (off_c[15:OFF_W] == '0);
    wr_div      = cpu_do_write & data_active & (off_c[OFF_W-1:0] == OFF_DIV);
    wr_tima     = cpu_do_write & data_active & (off_c[OFF_W-1:0] == OFF_TIMA);
    wr_tma      = cpu_do_write & data_active & (off_c[OFF_W-1:0] == OFF_TMA);
    wr_tac      = cpu_do_write & data_active & (off_c[OFF_W-1:0] == OFF_TAC);
  end

  // Combinational read mux
  always_comb begin
    data_r = 8'hFF;
    if (data_active) begin
      case (off_c[OFF_W-1:0])
        OFF_DIV:  data_r = div_val;
        OFF_TIMA: data_r = tima_q;
        OFF_TMA:  data_r = tma_q;
        default:  data_r = {5'b11111, tac_q};
      endcase
    end
  end

  // Plain configuration registers (next values feed the reload and prescaler)
  always_comb begin
    tma_d = wr_tma ? cpu_data_w : tma_q;
    tac_d = wr_tac ? cpu_data_w[2:0] : tac_q;
  end

  // TIMA / overflow FSM next state
  always_comb begin
    state_d   = state_q;
    tima_d    = tima_q;
    ovf_cnt_d = ovf_cnt_q;
    irq_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wr_tima) begin
          tima_d = cpu_data_w;
        end else if (tick_c) begin
          if (tima_q == 8'hFF) begin
            tima_d    = '0;
            ovf_cnt_d = '0;
            state_d   = ST_OVF;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      ST_OVF: begin
        if (ovf_cnt_q == OC_LAST) begin
          // Exit cycle: reload wins over TIMA writes and ticks
          tima_d  = tma_d;
          irq_d   = 1'b1;
          state_d = ST_RUN;
        end else if (wr_tima) begin
          tima_d  = cpu_data_w;
          state_d = ST_RUN;
        end else begin
          ovf_cnt_d = ovf_cnt_q + OC_W'(1);
          if (tick_c) begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      tima_q    <= '0;
      tma_q     <= '0;
      tac_q     <= '0;
      ovf_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      ovf_cnt_q <= ovf_cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer.sv
// Testbench for timer: directed scenarios plus randomized traffic against a behavioural model.
module tb_timer;

  localparam logic [15:0] BASE      = 16'hFF04;
  localparam int          OVF_DELAY = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic        cpu_do_write;
  logic [7:0]  data_r;
  logic        data_active;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_cnt, m_tac, m_tma, m_tima, m_wait;
  bit m_irq;

  timer #(.BASE(BASE), .OVF_DELAY(OVF_DELAY)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data_w   (cpu_data_w),
    .cpu_do_write (cpu_do_write),
    .data_r       (data_r),
    .data_active  (data_active),
    .irq          (irq)
  );

  always #10 clk = ~clk;

  function automatic bit m_sig(input int cnt, input int tac);
    int tap;
    case (tac & 3)
      0:       tap = 9;
      1:       tap = 3;
      2:       tap = 5;
      default: tap = 7;
    endcase
    return (((tac >> 2) & 1) != 0) && (((cnt >> tap) & 1) != 0);
  endfunction

  // One clock of the reference model; m_wait counts cycles left until reload
  task automatic m_step(input bit rst, input bit we, input logic [15:0] a, input logic [7:0] d);
    int off, ncnt, ntac, ntma;
    bit hit, tick;
    if (rst) begin
      m_cnt = 0; m_tac = 0; m_tma = 0; m_tima = 0; m_wait = 0; m_irq = 0;
      return;
    end
    off  = (int'(a) - int'(BASE) + 65536) % 65536;
    hit  = we && (off < 4);
    ncnt = (hit && off == 0) ? 0 : (m_cnt + 1) % 65536;
    ntac = (hit && off == 3) ? (int'(d) & 7) : m_tac;
    ntma = (hit && off == 2) ? int'(d) : m_tma;
    tick = m_sig(m_cnt, m_tac) && !m_sig(ncnt, ntac);
`ifndef TIMER_DIV_GLITCH_EN
    if (hit && (off == 0 || off == 3)) tick = 0;
`endif
    m_irq = 0;
    if (m_wait == 1) begin
      m_tima = ntma; m_irq = 1; m_wait = 0;
    end else if (hit && off == 1) begin
      m_tima = int'(d); m_wait = 0;
    end else if (m_wait > 1) begin
      m_wait--;
      if (tick) m_tima = (m_tima + 1) % 256;
    end else if (tick) begin
      if (m_tima == 255) begin
        m_tima = 0; m_wait = OVF_DELAY;
      end else begin
        m_tima++;
      end
    end
    m_cnt = ncnt; m_tac = ntac; m_tma = ntma;
  endtask

  // Drive one cycle at negedge, advance model at posedge, return at posedge+1
  task automatic cyc(input bit rst, input bit we, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    reset = rst; cpu_do_write = we; cpu_addr = a; cpu_data_w = d;
    @(posedge clk);
    m_step(rst, we, a, d);
    #1;
    reset = 1'b0; cpu_do_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE + 16'd8, 8'h00);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v, output logic act);
    cpu_addr = a;
    #1;
    v   = data_r;
    act = data_active;
  endtask

  // Reset, TAC=05, TMA=tma, TIMA=FF, DIV clear, then 16 cycles: overflow just taken
  task automatic ovf_setup(input logic [7:0] tma);
    cyc(1'b1, 1'b0, BASE, 8'h00);
    cyc(1'b0, 1'b1, BASE + 16'd3, 8'h05);
    cyc(1'b0, 1'b1, BASE + 16'd2, tma);
    cyc(1'b0, 1'b1, BASE + 16'd1, 8'hFF);
    cyc(1'b0, 1'b1, BASE, 8'h5C);
    idle(16);
  endtask

  task automatic test_reset;
    logic [7:0] v; logic act;
    cyc(1'b1, 1'b0, BASE, 8'h00);
    cyc(1'b0, 1'b1, BASE + 16'd1, 8'h77);
    cyc(1'b0, 1'b1, BASE + 16'd2, 8'h66);
    cyc(1'b1, 1'b1, BASE + 16'd1, 8'h5A);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rd(BASE, v, act);
    checks++; if (v !== 8'h00 || act !== 1'b1) begin errors++; $display("FAIL reset_div: got %02h/%b expected 00/1", v, act); end
    rd(BASE + 16'd1, v, act);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_tima: got %02h expected 00", v); end
    rd(BASE + 16'd2, v, act);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_tma: got %02h expected 00", v); end
    rd(BASE + 16'd3, v, act);
    checks++; if (v !== 8'hF8) begin errors++; $display("FAIL reset_tac: got %02h expected F8", v); end
  endtask

  task automatic test_prescale;
    logic [7:0] v; logic act;
    cyc(1'b1, 1'b0, BASE, 8'h00);
    cyc(1'b0, 1'b1, BASE + 16'd3, 8'h05);
    cyc(1'b0, 1'b1, BASE, 8'hAB);
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      rd(BASE + 16'd1, v, act);
      checks++;
      if (v !== ((k == 16) ? 8'h01 : 8'h00)) begin
        errors++; $display("FAIL prescale_tima cycle %0d: got %02h expected %02h", k, v, (k == 16) ? 8'h01 : 8'h00);
      end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prescale_irq cycle %0d: got %b expected 0", k, irq); end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] v; logic act;
    ovf_setup(8'hA0);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) idle(1);
      rd(BASE + 16'd1, v, act);
      checks++;
      if (v !== ((k >= 4) ? 8'hA0 : 8'h00)) begin
        errors++; $display("FAIL ovf_tima step %0d: got %02h expected %02h", k, v, (k >= 4) ? 8'hA0 : 8'h00);
      end
      checks++;
      if (irq !== (k == 4)) begin errors++; $display("FAIL ovf_irq step %0d: got %b expected %b", k, irq, k == 4); end
    end
  endtask

  task automatic test_ovf_cancel;
    logic [7:0] v; logic act;
    ovf_setup(8'hA0);
    idle(1);
    cyc(1'b0, 1'b1, BASE + 16'd1, 8'h33);
    for (int k = 0; k < 6; k++) begin
      rd(BASE + 16'd1, v, act);
      checks++; if (v !== 8'h33) begin errors++; $display("FAIL cancel_tima step %0d: got %02h expected 33", k, v); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cancel_irq step %0d: got %b expected 0", k, irq); end
      idle(1);
    end
  endtask

  task automatic test_exit_writes;
    logic [7:0] v; logic act;
    ovf_setup(8'hA0);
    idle(3);
    cyc(1'b0, 1'b1, BASE + 16'd2, 8'h55);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL exit_tma_irq: got %b expected 1", irq); end
    rd(BASE + 16'd1, v, act);
    checks++; if (v !== 8'h55) begin errors++; $display("FAIL exit_tma_tima: got %02h expected 55", v); end
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL exit_tma_irq_len: got %b expected 0", irq); end
    ovf_setup(8'hA0);
    idle(3);
    cyc(1'b0, 1'b1, BASE + 16'd1, 8'h77);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL exit_tima_irq: got %b expected 1", irq); end
    rd(BASE + 16'd1, v, act);
    checks++; if (v !== 8'hA0) begin errors++; $display("FAIL exit_tima_ignored: got %02h expected A0", v); end
  endtask

  task automatic test_div_glitch;
    logic [7:0] v; logic act;
    logic [7:0] exp_tima;
`ifdef TIMER_DIV_GLITCH_EN
    exp_tima = 8'h01;
`else
    exp_tima = 8'h00;
`endif
    cyc(1'b1, 1'b0, BASE, 8'h00);
    cyc(1'b0, 1'b1, BASE + 16'd3, 8'h04);
    idle(600);
    rd(BASE, v, act);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL glitch_div_pre: got %02h expected 02", v); end
    rd(BASE + 16'd1, v, act);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL glitch_tima_pre: got %02h expected 00", v); end
    cyc(1'b0, 1'b1, BASE, 8'hC3);
    rd(BASE, v, act);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL glitch_div_clr: got %02h expected 00", v); end
    rd(BASE + 16'd1, v, act);
    checks++; if (v !== exp_tima) begin errors++; $display("FAIL glitch_tima: got %02h expected %02h", v, exp_tima); end
  endtask

  task automatic test_misc;
    logic [7:0] v; logic act;
    cyc(1'b1, 1'b0, BASE, 8'h00);
    cyc(1'b0, 1'b1, BASE + 16'd3, 8'h00);
    rd(BASE + 16'd3, v, act);
    checks++; if (v !== 8'hF8) begin errors++; $display("FAIL tac_read00: got %02h expected F8", v); end
    cyc(1'b0, 1'b1, BASE + 16'd3, 8'hFE);
    rd(BASE + 16'd3, v, act);
    checks++; if (v !== 8'hFE) begin errors++; $display("FAIL tac_readFE: got %02h expected FE", v); end
    rd(16'hFF08, v, act);
    checks++; if (v !== 8'hFF || act !== 1'b0) begin errors++; $display("FAIL ff08_read: got %02h/%b expected FF/0", v, act); end
    rd(16'hFF03, v, act);
    checks++; if (v !== 8'hFF || act !== 1'b0) begin errors++; $display("FAIL ff03_read: got %02h/%b expected FF/0", v, act); end
    cyc(1'b0, 1'b1, 16'hFF08, 8'h12);
    rd(BASE + 16'd2, v, act);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL foreign_write: got %02h expected 00", v); end
    // Reset in the middle of the overflow delay
    ovf_setup(8'hA0);
    idle(1);
    cyc(1'b1, 1'b0, BASE + 16'd8, 8'h00);
    rd(BASE + 16'd1, v, act);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_ovf_tima: got %02h expected 00", v); end
    rd(BASE + 16'd2, v, act);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_ovf_tma: got %02h expected 00", v); end
    rd(BASE + 16'd3, v, act);
    checks++; if (v !== 8'hF8) begin errors++; $display("FAIL rst_ovf_tac: got %02h expected F8", v); end
    rd(BASE, v, act);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_ovf_div: got %02h expected 00", v); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_ovf_irq step %0d: got %b expected 0", k, irq); end
      idle(1);
    end
  endtask

  // Compare DUT against model for n cycles of randomized bus traffic
  task automatic run_random(input int n, input int rst_pct);
    logic [7:0] v, d; logic act;
    logic [15:0] a;
    bit we, rst;
    int r;
    for (int i = 0; i < n; i++) begin
      rst = ($urandom_range(0, 999) < rst_pct);
      we  = ($urandom_range(0, 99) < 40);
      r   = $urandom_range(0, 99);
      d   = 8'($urandom);
      if (r < 4) a = BASE;
      else if (r < 24) begin
        a = BASE + 16'd1;
        if ($urandom_range(0, 1) == 1) d = 8'hFC + 8'($urandom_range(0, 3));
      end else if (r < 40) begin
        a = BASE + 16'd2;
        if ($urandom_range(0, 1) == 1) d = 8'hFE + 8'($urandom_range(0, 1));
      end else if (r < 52) begin
        a = BASE + 16'd3;
        if ($urandom_range(0, 3) != 0) d[2] = 1'b1;
      end else a = 16'($urandom);
      cyc(rst, we, a, d);
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq cyc %0d: got %b expected %b", i, irq, m_irq); end
      rd(BASE, v, act);
      checks++; if (v !== 8'(m_cnt >> 8)) begin errors++; $display("FAIL rnd_div cyc %0d: got %02h expected %02h", i, v, 8'(m_cnt >> 8)); end
      rd(BASE + 16'd1, v, act);
      checks++; if (v !== 8'(m_tima)) begin errors++; $display("FAIL rnd_tima cyc %0d: got %02h expected %02h", i, v, 8'(m_tima)); end
      rd(BASE + 16'd2, v, act);
      checks++; if (v !== 8'(m_tma)) begin errors++; $display("FAIL rnd_tma cyc %0d: got %02h expected %02h", i, v, 8'(m_tma)); end
      rd(BASE + 16'd3, v, act);
      checks++; if (v !== (8'hF8 | 8'(m_tac))) begin errors++; $display("FAIL rnd_tac cyc %0d: got %02h expected %02h", i, v, 8'hF8 | 8'(m_tac)); end
      rd(a, v, act);
      checks++;
      if (act !== (((int'(a) - int'(BASE) + 65536) % 65536) < 4)) begin
        errors++; $display("FAIL rnd_active addr %04h: got %b", a, act);
      end
    end
  endtask

  task automatic test_back_to_back;
    int irqs;
    ovf_setup(8'hFF);
    irqs = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL b2b_irq step %0d: got %b expected %b", i, irq, m_irq); end
      if (irq === 1'b1) irqs++;
    end
    checks++; if (irqs != 3) begin errors++; $display("FAIL b2b_irq_count: got %0d expected 3", irqs); end
  endtask

  task automatic test_random;
    cyc(1'b1, 1'b0, BASE, 8'h00);
    run_random(3000, 3);
  endtask

  initial begin
    reset = 1'b1; cpu_do_write = 1'b0; cpu_addr = 16'h0000; cpu_data_w = 8'h00;
    m_cnt = 0; m_tac = 0; m_tma = 0; m_tima = 0; m_wait = 0; m_irq = 0;
    test_reset();
    test_prescale();
    test_overflow();
    test_ovf_cancel();
    test_exit_writes();
    test_div_glitch();
    test_misc();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter BASE, default 16'hFF04, address of DIV; TIMA/TMA/TAC at BASE+1/+2/+3.
REQ-002 Parameter OVF_DELAY, default 4, clk cycles between TIMA overflow and reload.
REQ-003 clk  input  1  system clock, all state on posedge; one clock, synchronous active-high reset (fixed decision).
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 cpu_addr  input  16  CPU bus address.
REQ-006 cpu_data_w  input  8  CPU write data.
REQ-007 cpu_do_write  input  1  write strobe, sampled on posedge.
REQ-008 data_r  output  8  register read data, combinational from cpu_addr.
REQ-009 data_active  output  1  high when cpu_addr in BASE..BASE+3, combinational.
REQ-010 irq  output  1  timer interrupt request, one-cycle pulse.

Function
REQ-011 16-bit free-running counter SHALL increment by 1 every clk, wrapping FFFF->0000.
REQ-012 DIV read SHALL return counter[15:8]; any DIV write SHALL clear the full 16-bit counter next cycle, data ignored.
REQ-013 TAC[1:0] SHALL select tap: 00->bit 9, 01->bit 3, 10->bit 5, 11->bit 7.
REQ-014 Tick SHALL be a 1->0 transition of (counter[tap] & TAC[2]) between consecutive cycles.
REQ-015 Each tick in RUN SHALL increment TIMA; TIMA FF + tick SHALL go to 00 and enter OVF.
REQ-016 States: RUN, OVF; OVF holds TIMA=00 for OVF_DELAY cycles, then in the exit cycle TIMA<=TMA, irq=1 for that one cycle, return to RUN.
REQ-017 Reload SHALL use TMA value current in the exit cycle, including a same-cycle TMA write (new value).
REQ-018 CPU write to TIMA during OVF (before exit cycle) SHALL store the data, cancel reload and irq, return to RUN.
REQ-019 CPU write to TIMA in the exit cycle SHALL be ignored; TMA reload wins.
REQ-020 Ticks during OVF SHALL increment TIMA from 00 without leaving OVF.
REQ-021 CPU write to TIMA in RUN coinciding with a tick: written value wins, tick dropped.
REQ-022 Reads: TIMA, TMA plain; TAC returns {5'b11111, TAC[2:0]}; data_r=8'hFF when data_active low.
REQ-023 Writes take effect at the posedge where cpu_do_write=1 and address matches; other addresses ignored.

Reset
REQ-024 reset SHALL clear counter, TIMA, TMA, TAC, edge history; state=RUN; irq=0.
REQ-025 reset during OVF SHALL abort pending reload with no irq.
REQ-026 Reset SHALL take priority over all CPU writes in the same cycle.

Configuration
REQ-027 Macro TIMER_DIV_GLITCH_EN: when defined, a DIV write or TAC write that drops (counter[tap] & TAC[2]) from 1 to 0 SHALL produce a tick.
REQ-028 Without TIMER_DIV_GLITCH_EN, edge history SHALL be re-sampled after DIV/TAC writes, suppressing such ticks; only natural counter carries tick.

Structure
REQ-029 Shared package SHALL hold register offsets (DIV/TIMA/TMA/TAC), TAC tap-select mapping, state encoding.
REQ-030 Sub-module timer_prescaler SHALL own the 16-bit counter, tap mux and falling-edge detector, outputting tick and DIV.
REQ-031 Top SHALL own TIMA/TMA/TAC, OVF FSM, bus decode; instantiated from main with data_active in the read mux and irq to the interrupt logic.

Verification
REQ-032 TAC=05, TIMA=00, run 16 clk from counter 0 -> TIMA=01 exactly at 16th cycle, no irq.
REQ-033 TAC=05, TMA=A0, TIMA=FF, tick -> TIMA=00 for 4 cycles, then TIMA=A0 and irq high exactly 1 cycle.
REQ-034 Overflow as above, write TIMA=33 at delay cycle 2 -> TIMA=33, no reload, no irq.
REQ-035 Overflow, write TMA=55 in exit cycle -> TIMA=55, irq pulses; TIMA write in exit cycle ignored.
REQ-036 TAC=04, counter[9]=1, write DIV -> counter=0000; TIMA+1 with TIMER_DIV_GLITCH_EN, unchanged without.
REQ-037 Read TAC after write 8'h00 -> F8; read FF08 -> data_active=0, data_r=FF; reset in OVF -> no irq, all registers 00.
